// File: rtl/adc_dual_spi_resp_pkg.sv
// Shared definitions for the dual-channel ADC SPI responder and the acquisition block.
package adc_dual_spi_resp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StQuiet,
        StDone
    } adc_state_e;

    // One ADC frame on the wire: leading zeros followed by the sample bits.
    localparam int unsigned FrameLen = 16;
    localparam int unsigned BitCntW  = 4;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_dual_spi_resp_spi_clk_gen.sv
// SCLK generator: DIV cycles low, DIV cycles high, with strobes marking the toggle edges.
module adc_dual_spi_resp_spi_clk_gen #(
    parameter int unsigned DIV   = 2,
    parameter int unsigned CNT_W = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,  // frame start: SCLK drops low on this edge
    input  logic run,   // keep toggling; when low SCLK parks high
    output logic sclk,
    output logic rise,  // this edge takes SCLK low-to-high (data sample point)
    output logic fall   // this edge takes SCLK high-to-low
);

    localparam logic [CNT_W-1:0] PhLast = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] phase;
    logic             tick;

    assign tick = (phase == PhLast);
    assign rise = tick & ~sclk;
    assign fall = tick & sclk;

    // Phase counter and registered SCLK; parking high keeps the line glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            sclk  <= 1'b1;
        end else if (load) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else if (run) begin
            if (tick) begin
                phase <= '0;
                sclk  <= ~sclk;
            end else begin
                phase <= phase + 1'b1;
            end
        end else begin
            phase <= '0;
            sclk  <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_dual_spi_resp.sv
// Dual-channel (current/voltage) ADC SPI reader sharing CS_N and SCLK.
module adc_dual_spi_resp
    import adc_dual_spi_resp_pkg::*;
#(
    parameter int unsigned M     = 12,
    parameter int unsigned DIV   = 2,
    parameter int unsigned QUIET = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_adc,
    input  logic         sdata_i,
    input  logic         sdata_v,
    output logic         cs_n,
    output logic         sclk,
    output logic         eoc,
    output logic [M-1:0] i,
    output logic [M-1:0] v,
    output logic         fmt_err
);

    localparam int unsigned          PhW       = cnt_width((DIV > QUIET) ? DIV : QUIET);
    localparam logic [BitCntW-1:0]   LastBit   = BitCntW'(FrameLen - 1);
    localparam logic [BitCntW-1:0]   LeadBits  = BitCntW'(FrameLen - M);
    localparam logic [PhW-1:0]       QuietLast = PhW'(QUIET - 1);

    adc_state_e         state;
    logic [BitCntW-1:0] bit_cnt;
    logic [PhW-1:0]     quiet_cnt;
    logic [M-1:0]       sr_i;
    logic [M-1:0]       sr_v;
    logic               err;
    logic               clk_load;
    logic               clk_run;
    logic               clk_rise;
    logic               clk_fall;
    logic               last_fall;

    // The falling edge after bit 15 ends the frame; SCLK must stay high there.
    assign clk_load  = (state == StIdle) && start_adc;
    assign last_fall = clk_fall && (bit_cnt == LastBit);
    assign clk_run   = (state == StConv) && !last_fall;

    adc_dual_spi_resp_spi_clk_gen #(
        .DIV   (DIV),
        .CNT_W (PhW)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (clk_load),
        .run   (clk_run),
        .sclk  (sclk),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    // Frame sequencer: capture bits on SCLK rise, publish results only in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            sr_i      <= '0;
            sr_v      <= '0;
            err       <= 1'b0;
            cs_n      <= 1'b1;
            eoc       <= 1'b0;
            i         <= '0;
            v         <= '0;
            fmt_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_adc) begin
                        state   <= StConv;
                        cs_n    <= 1'b0;
                        bit_cnt <= '0;
                        err     <= 1'b0;
                        sr_i    <= '0;
                        sr_v    <= '0;
                    end
                end
                StConv: begin
                    if (clk_rise) begin
                        if (bit_cnt < LeadBits) begin
                            err <= err | sdata_i | sdata_v;
                        end else begin
                            sr_i <= {sr_i[M-2:0], sdata_i};
                            sr_v <= {sr_v[M-2:0], sdata_v};
                        end
                    end
                    if (last_fall) begin
                        state     <= StQuiet;
                        cs_n      <= 1'b1;
                        quiet_cnt <= '0;
                    end else if (clk_fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StQuiet: begin
                    if (quiet_cnt == QuietLast) begin
                        state   <= StDone;
                        eoc     <= 1'b1;
                        i       <= sr_i;
                        v       <= sr_v;
                        fmt_err <= err;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    eoc   <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_dual_spi_resp.sv
// Self-checking bench: default build (DIV=2, QUIET=4) and a fast build (DIV=1, QUIET=1).
module tb_adc_dual_spi_resp;

    localparam int unsigned M      = 12;
    localparam int unsigned DIV0   = 2;
    localparam int unsigned QUIET0 = 4;
    localparam int unsigned DIV1   = 1;
    localparam int unsigned QUIET1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic [1:0] sdi = '0;
    logic [1:0] sdv = '0;
    logic csn0, sck0, eoc0, fe0, csn1, sck1, eoc1, fe1;
    logic [M-1:0] i0, v0, i1, v1;

    always #5 clk = ~clk;

    adc_dual_spi_resp #(.M(M), .DIV(DIV0), .QUIET(QUIET0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_adc(start0), .sdata_i(sdi[0]), .sdata_v(sdv[0]),
        .cs_n(csn0), .sclk(sck0), .eoc(eoc0), .i(i0), .v(v0), .fmt_err(fe0)
    );

    adc_dual_spi_resp #(.M(M), .DIV(DIV1), .QUIET(QUIET1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_adc(start1), .sdata_i(sdi[1]), .sdata_v(sdv[1]),
        .cs_n(csn1), .sclk(sck1), .eoc(eoc1), .i(i1), .v(v1), .fmt_err(fe1)
    );

    // ADC model state: per-DUT queue of 16-bit frames, consumed one per CS_N assertion.
    logic [15:0]  fw_i [2][8];
    logic [15:0]  fw_v [2][8];
    logic [15:0]  cur_i [2];
    logic [15:0]  cur_v [2];
    int           fcnt [2];
    int           bidx [2];
    logic         prev_cs [2];
    logic         prev_sck [2];
    logic [M-1:0] last_i [2];
    logic [M-1:0] last_v [2];
    int           n_pass = 0;
    int           n_total = 0;

    function automatic logic csn_of(input int d);
        return (d == 0) ? csn0 : csn1;
    endfunction
    function automatic logic sck_of(input int d);
        return (d == 0) ? sck0 : sck1;
    endfunction
    function automatic logic eoc_of(input int d);
        return (d == 0) ? eoc0 : eoc1;
    endfunction
    function automatic logic fe_of(input int d);
        return (d == 0) ? fe0 : fe1;
    endfunction
    function automatic logic [M-1:0] i_of(input int d);
        return (d == 0) ? i0 : i1;
    endfunction
    function automatic logic [M-1:0] v_of(input int d);
        return (d == 0) ? v0 : v1;
    endfunction

    // ADC behaviour: bit 0 appears when CS_N falls, each later bit after an SCLK fall, MSB first.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (csn_of(d)) begin
                bidx[d] = 0;
            end else if (prev_cs[d]) begin
                cur_i[d] = fw_i[d][fcnt[d] % 8];
                cur_v[d] = fw_v[d][fcnt[d] % 8];
                fcnt[d]  = fcnt[d] + 1;
                bidx[d]  = 0;
            end else if (prev_sck[d] && !sck_of(d) && bidx[d] < 15) begin
                bidx[d] = bidx[d] + 1;
            end
            sdi[d] = cur_i[d][15 - bidx[d]];
            sdv[d] = cur_v[d][15 - bidx[d]];
            prev_cs[d]  = csn_of(d);
            prev_sck[d] = sck_of(d);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_start(input int d, input logic val);
        if (d == 0) start0 = val;
        else start1 = val;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = {4'h0, 12'($urandom)};
        if ($urandom_range(0, 3) == 0) w[12 + $urandom_range(0, 3)] = 1'b1;
        return w;
    endfunction

    // One single-pulse frame; EOC is expected in cycle 32*DIV+QUIET+1 counted from the
    // edge that sampled START_ADC (cycle k lies between that edge +k-1 and +k).
    task automatic run_frame(input int d, input logic [15:0] wi, input logic [15:0] wv,
                             input string tag);
        int dv, qt, lat_exp, lat, low_cnt, hi_cnt, rises;
        logic prev_s;
        logic [M-1:0] exp_i, exp_v;
        logic exp_f;
        dv      = (d == 0) ? DIV0 : DIV1;
        qt      = (d == 0) ? QUIET0 : QUIET1;
        lat_exp = 32 * dv + qt + 1;
        fw_i[d][fcnt[d] % 8] = wi;
        fw_v[d][fcnt[d] % 8] = wv;
        exp_i = wi[M-1:0];
        exp_v = wv[M-1:0];
        exp_f = (|wi[15:M]) | (|wv[15:M]);
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        #1;
        set_start(d, 1'b0);
        lat = 0; low_cnt = 0; hi_cnt = 0; rises = 0; prev_s = 1'b1;
        for (int k = 1; k <= lat_exp + 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == lat_exp / 2) check({tag, " i_hidden_midframe"}, 32'(i_of(d)), 32'(last_i[d]));
            if (!csn_of(d)) begin
                low_cnt++;
                if (sck_of(d)) hi_cnt++;
                if (!prev_s && sck_of(d)) rises++;
            end
            prev_s = sck_of(d);
            if (eoc_of(d)) lat = k;
        end
        check({tag, " eoc_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " i"}, 32'(i_of(d)), 32'(exp_i));
        check({tag, " v"}, 32'(v_of(d)), 32'(exp_v));
        check({tag, " fmt_err"}, 32'(fe_of(d)), 32'(exp_f));
        check({tag, " cs_low_cycles"}, 32'(low_cnt), 32'(32 * dv));
        check({tag, " sclk_high_cycles"}, 32'(hi_cnt), 32'(16 * dv));
        check({tag, " sclk_rises"}, 32'(rises), 32'd16);
        @(negedge clk);
        check({tag, " eoc_one_cycle"}, 32'(eoc_of(d)), 32'd0);
        last_i[d] = exp_i;
        last_v[d] = exp_v;
    endtask

    // START_ADC held high for three frames: EOC spacing, data order, CS_N gap.
    task automatic back_to_back();
        logic [15:0] wi [3];
        logic [15:0] wv [3];
        int t_eoc [3];
        logic [M-1:0] got_i [3];
        logic [M-1:0] got_v [3];
        int runs [4];
        int n_eoc, n_runs, run;
        logic seen_low;
        wi = '{16'h0FFF, 16'h0000, 16'h0800};
        wv = '{16'h0123, 16'h0456, 16'h0789};
        for (int j = 0; j < 3; j++) begin
            fw_i[0][(fcnt[0] + j) % 8] = wi[j];
            fw_v[0][(fcnt[0] + j) % 8] = wv[j];
            t_eoc[j] = 0;
            got_i[j] = '0;
            got_v[j] = '0;
        end
        for (int j = 0; j < 4; j++) runs[j] = 0;
        n_eoc = 0; n_runs = 0; run = 0; seen_low = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 0; k < 400 && n_eoc < 3; k++) begin
            @(negedge clk);
            if (csn0) begin
                run++;
            end else begin
                if (seen_low && run > 0 && n_runs < 4) begin
                    runs[n_runs] = run;
                    n_runs++;
                end
                run = 0;
                seen_low = 1'b1;
            end
            if (eoc0) begin
                t_eoc[n_eoc] = k;
                got_i[n_eoc] = i0;
                got_v[n_eoc] = v0;
                n_eoc++;
                if (n_eoc == 3) start0 = 1'b0;
            end
        end
        start0 = 1'b0;
        check("b2b eoc_count", 32'(n_eoc), 32'd3);
        check("b2b gap_1_2", 32'(t_eoc[1] - t_eoc[0]), 32'(32 * DIV0 + QUIET0 + 2));
        check("b2b gap_2_3", 32'(t_eoc[2] - t_eoc[1]), 32'(32 * DIV0 + QUIET0 + 2));
        for (int j = 0; j < 3; j++) begin
            check($sformatf("b2b i_%0d", j), 32'(got_i[j]), 32'(wi[j][M-1:0]));
            check($sformatf("b2b v_%0d", j), 32'(got_v[j]), 32'(wv[j][M-1:0]));
        end
        check("b2b cs_high_run_count", 32'(n_runs), 32'd2);
        check("b2b cs_high_run_0", 32'(runs[0]), 32'(QUIET0 + 2));
        check("b2b cs_high_run_1", 32'(runs[1]), 32'(QUIET0 + 2));
        repeat (8) @(negedge clk);
        check("b2b no_fourth_frame", 32'(csn0), 32'd1);
        last_i[0] = wi[2][M-1:0];
        last_v[0] = wv[2][M-1:0];
    endtask

    // START_ADC chatter during CONV/QUIET/DONE must not add frames.
    task automatic toggle_during_frame();
        int lat_exp, n_eoc, lat;
        logic [M-1:0] cap_i;
        lat_exp = 32 * DIV0 + QUIET0 + 1;
        fw_i[0][fcnt[0] % 8] = 16'h0C3C;
        fw_v[0][fcnt[0] % 8] = 16'h03C3;
        n_eoc = 0; lat = 0; cap_i = '0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (k < lat_exp) start0 = 1'($urandom_range(0, 1));
            else start0 = 1'b0;
            if (eoc0) begin
                n_eoc++;
                if (n_eoc == 1) begin
                    lat = k;
                    cap_i = i0;
                end
            end
        end
        check("toggle eoc_count", 32'(n_eoc), 32'd1);
        check("toggle eoc_latency", 32'(lat), 32'(lat_exp));
        check("toggle i", 32'(cap_i), 32'h0C3C);
        last_i[0] = 12'hC3C;
        last_v[0] = 12'h3C3;
    endtask

    // Reset asserted between clock edges in cycle 30 of CONV.
    task automatic reset_mid_frame();
        int n_eoc;
        fw_i[0][fcnt[0] % 8] = 16'h0ABC;
        fw_v[0][fcnt[0] % 8] = 16'h0DEF;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        check("rst_mid pre_cs_low", 32'(csn0), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid cs_n", 32'(csn0), 32'd1);
        check("rst_mid sclk", 32'(sck0), 32'd1);
        check("rst_mid eoc", 32'(eoc0), 32'd0);
        check("rst_mid i", 32'(i0), 32'd0);
        check("rst_mid v", 32'(v0), 32'd0);
        check("rst_mid fmt_err", 32'(fe0), 32'd0);
        n_eoc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (eoc0) n_eoc++;
        end
        check("rst_mid no_eoc_after_abort", 32'(n_eoc), 32'd0);
        last_i[0] = '0;
        last_v[0] = '0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 8; j++) begin
                fw_i[d][j] = '0;
                fw_v[d][j] = '0;
            end
            cur_i[d] = '0;
            cur_v[d] = '0;
            fcnt[d] = 0;
            bidx[d] = 0;
            prev_cs[d] = 1'b1;
            prev_sck[d] = 1'b1;
            last_i[d] = '0;
            last_v[d] = '0;
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cs_n", 32'(csn0), 32'd1);
        check("reset sclk", 32'(sck0), 32'd1);
        check("reset eoc", 32'(eoc0), 32'd0);
        check("reset i", 32'(i0), 32'd0);
        check("reset v", 32'(v0), 32'd0);
        check("reset fmt_err", 32'(fe0), 32'd0);
        check("reset fast cs_n", 32'(csn1), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(0, 16'h0A5A, 16'h05A5, "basic");
        run_frame(0, 16'h0A5A, 16'h45A5, "lead_err_v");
        for (int r = 0; r < 3; r++) run_frame(0, rand_word(), rand_word(), $sformatf("rand%0d", r));
        back_to_back();
        toggle_during_frame();
        reset_mid_frame();
        run_frame(0, rand_word(), {4'h0, 12'($urandom)}, "post_reset");

        run_frame(1, 16'h0A5A, 16'h05A5, "fast basic");
        run_frame(1, 16'h8123, 16'h0FED, "fast lead_err_i");
        run_frame(1, rand_word(), rand_word(), "fast rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
